cic_comb_decim: RTL and testbench
=================================

// Module: cic_comb_decim
// PURPOSE
//  Downstream neighbour of the CIC integrator stage: decimates the integrator output by a
//  runtime ratio, then applies N pipelined comb sections (y = x - x[n-M]) at the low rate.
//  Completes the CIC decimator chain and feeds the rest of the DFE array.
// PARAMETERS
//  DATA_WIDTH  16  sample width, two's complement, in and out
//  N_STAGES    3   comb sections, >=1
//  DIFF_DELAY  1   comb differential delay M in decimated samples, 1 or 2
//  R_WIDTH     8   width of decim_r
//  OUT_SHIFT   0   arithmetic right shift applied to last comb result, 0..DATA_WIDTH-1
// PORTS
//  clk        in   1           single clock, rising edge
//  rst_n      in   1           asynchronous active-low reset
//  en         in   1           input sample valid, one sample per cycle when high
//  in         in   DATA_WIDTH  signed integrator output
//  decim_r    in   R_WIDTH     decimation ratio R; 0 and 1 both mean pass-through (R=1)
//  out_valid  out  1           one-cycle strobe, new decimated sample on out
//  out        out  DATA_WIDTH  signed comb output, held between strobes
// BEHAVIOUR
//  Reset (async, rst_n low): phase counter, all comb registers, delay lines, valid pipe,
//   out and out_valid clear to 0 immediately. Reset mid-operation discards in-flight samples.
//   First accepted sample after release sees all-zero history.
//  Decimation:
//   - phase counter advances only on cycles with en=1; en=0 freezes all state except valid pipe.
//   - sample accepted (strobe) when en=1 and counter==0; counter then counts to Reff-1 and
//     wraps to 0. Reff = max(decim_r,1). First en after reset is always accepted.
//   - decim_r read each cycle: if counter >= Reff-1 at an en cycle, counter wraps to 0.
//     A lowered ratio therefore takes effect by the next wrap; no lockup.
//  Comb pipeline:
//   - stage k (1..N_STAGES) has one output register, a DIFF_DELAY-deep history and a valid bit.
//   - stage k updates only when its input valid is high: y_k <= x_k - hist_k[M-1];
//     hist shifts in x_k. Stage 1 input = accepted sample; stage k input = y_(k-1).
//   - all arithmetic DATA_WIDTH bits, modulo 2^DATA_WIDTH (wrap, no saturation); correct
//     CIC output relies on this wrap.
//   - out <= y_N >>> OUT_SHIFT, out_valid <= 1 in the same cycle the last stage updates.
//  Latency: accepted sample on cycle t -> out_valid high on cycle t+N_STAGES+1 (1 accept reg
//   + N_STAGES comb regs). Throughput up to one output per cycle (R=1).
//  out_valid is a single-cycle pulse per accepted sample; never asserted twice for one sample.
//  out holds its last value when out_valid is low.
//  en deassertion while samples are in flight does not stall the comb pipeline.
//  Simultaneous strobe and in-flight outputs: pipeline fully registered, no hazards.
// TESTING (N_STAGES=2, DIFF_DELAY=1, OUT_SHIFT=0, DATA_WIDTH=16 unless stated)
//  1 Step: R=4, en=1 always, in=100 constant -> out sequence 100, -100, 0, 0, ...;
//    one out_valid every 4 cycles; first strobe 3 cycles after first en.
//  2 Ramp: R=4, in=0,1,2,... one per en cycle -> accepted 0,4,8,12 -> out 0,4,0,0,...
//  3 Wrap: R=1, N_STAGES=1, in=32767 then -32768 -> out 32767 then 1 (modulo arithmetic).
//  4 Gated en: R=3, en toggling 1/0 each cycle -> strobe every 3rd en-high cycle (every 6 clk);
//    counter frozen on en=0 cycles; values match ungated run.
//  5 Ratio change: R=8 running, counter=5, decim_r set to 2 -> counter wraps on next en,
//    thereafter strobe every 2 en cycles; decim_r=0 -> behaves as R=1 (strobe every en).
//  6 Reset mid-flight: assert rst_n low with 2 samples in pipe -> out=0, out_valid=0 at once,
//    no strobe after release until new en; first post-reset sample in=50 -> out 50.

Source files
------------

// File: rtl/cic_comb_decim.sv
// CIC decimator back end: runtime-ratio decimation of the integrator stream
// followed by N pipelined comb sections running at the decimated rate.
module cic_comb_decim #(
  parameter int DATA_WIDTH = 16,
  parameter int N_STAGES   = 3,
  parameter int DIFF_DELAY = 1,
  parameter int R_WIDTH    = 8,
  parameter int OUT_SHIFT  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic [R_WIDTH-1:0]    decim_r,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out
);

  logic [R_WIDTH-1:0]    phase;
  logic [R_WIDTH-1:0]    phase_last;
  logic                  accept;
  logic                  acc_valid;
  logic [DATA_WIDTH-1:0] acc_data;

  logic [N_STAGES:0][DATA_WIDTH-1:0] x_bus;
  logic [N_STAGES:0]                 v_bus;

  // Ratios 0 and 1 both collapse to pass-through, so the last phase is 0.
  assign phase_last = (decim_r == '0) ? '0 : decim_r - R_WIDTH'(1);
  assign accept     = en && (phase == '0);

  // ">=" rather than "==" so a ratio lowered mid-count wraps instead of locking up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (en) begin
      phase <= (phase >= phase_last) ? '0 : phase + R_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_valid <= 1'b0;
      acc_data  <= '0;
    end else begin
      acc_valid <= accept;
      if (accept) begin
        acc_data <= in;
      end
    end
  end

  assign x_bus[0] = acc_data;
  assign v_bus[0] = acc_valid;

  for (genvar k = 0; k < N_STAGES; k++) begin : g_comb
    logic [DATA_WIDTH-1:0]                 y_q;
    logic                                  v_q;
    logic [DIFF_DELAY-1:0][DATA_WIDTH-1:0] hist;

    // Modulo subtraction is intentional: the integrators wrap, the combs undo it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        y_q  <= '0;
        v_q  <= 1'b0;
        hist <= '0;
      end else begin
        v_q <= v_bus[k];
        if (v_bus[k]) begin
          y_q     <= x_bus[k] - hist[DIFF_DELAY-1];
          hist[0] <= x_bus[k];
          for (int i = 1; i < DIFF_DELAY; i++) begin
            hist[i] <= hist[i-1];
          end
        end
      end
    end

    assign x_bus[k+1] = y_q;
    assign v_bus[k+1] = v_q;
  end

  // The last comb register doubles as the output register; it only changes on a strobe.
  assign out_valid = v_bus[N_STAGES];
  assign out      = $signed(x_bus[N_STAGES]) >>> OUT_SHIFT;

endmodule

// File: tb/tb_cic_comb_decim.sv
// Scoreboard bench for cic_comb_decim (N_STAGES=2, DIFF_DELAY=1): a stream-level
// model predicts each decimated output and its strobe cycle; a monitor checks them.
module tb_cic_comb_decim;

  localparam int DW  = 16;
  localparam int NS  = 2;
  localparam int M   = 1;
  localparam int RW  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [DW-1:0] in;
  logic [RW-1:0] decim_r;
  logic          out_valid;
  logic [DW-1:0] out;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // expected outputs and the cycle they must appear in
  logic [DW-1:0] exp_d[$];
  int            exp_c[$];
  logic [DW-1:0] last_out;

  // model: phase index plus the complete stream seen by each comb stage
  int            m_phase;
  logic [DW-1:0] s0[$];
  logic [DW-1:0] s1[$];

  cic_comb_decim #(
    .DATA_WIDTH(DW), .N_STAGES(NS), .DIFF_DELAY(M), .R_WIDTH(RW), .OUT_SHIFT(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in), .decim_r(decim_r),
    .out_valid(out_valid), .out(out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] comb_out(input logic [DW-1:0] s[$]);
    logic [DW-1:0] prev;
    prev = (s.size() > M) ? s[s.size()-1-M] : '0;
    return s[s.size()-1] - prev;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    s0.delete();
    s1.delete();
    exp_d.delete();
    exp_c.delete();
  endtask

  // one clock of stimulus; inputs become visible to the edge that follows
  task automatic drive(input logic e, input logic [DW-1:0] d, input int r);
    int reff;
    @(posedge clk);
    #1;
    en      = e;
    in      = d;
    decim_r = RW'(r);
    reff = (r == 0) ? 1 : r;
    if (e) begin
      if (m_phase == 0) begin
        s0.push_back(d);
        s1.push_back(comb_out(s0));
        exp_d.push_back(comb_out(s1));
        exp_c.push_back(cyc + 1 + NS);
      end
      m_phase = (m_phase >= reff - 1) ? 0 : m_phase + 1;
    end
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    en    = 1'b0;
    rst_n = 1'b0;
    model_reset();
    last_out = '0;
    #1;
    n_tests++;
    if (out !== '0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s out=%0d out_valid=%0b required out=0 out_valid=0", tag, $signed(out), out_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_tests++;
      if (out_valid) begin
        if (exp_d.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_strobe cyc=%0d out=%0d required no strobe", cyc, $signed(out));
        end else begin
          logic [DW-1:0] ed;
          int            ec;
          ed = exp_d.pop_front();
          ec = exp_c.pop_front();
          if (out !== ed || cyc != ec) begin
            n_fail++;
            $display("FAIL sample out=%0d at cyc %0d required %0d at cyc %0d",
                     $signed(out), cyc, $signed(ed), ec);
          end
        end
      end else if (out !== last_out) begin
        n_fail++;
        $display("FAIL hold out=%0d required %0d at cyc %0d", $signed(out), $signed(last_out), cyc);
      end
      last_out = out;
    end
  end

  initial begin
    int r;
    rst_n   = 1'b0;
    en      = 1'b0;
    in      = '0;
    decim_r = '0;
    model_reset();
    last_out = '0;
    repeat (2) @(posedge clk);
    #2;
    n_tests++;
    if (out !== '0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL por_state out=%0d out_valid=%0b required 0/0", $signed(out), out_valid);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // constant input at R=4: 100, -100, 0, ...
    for (int i = 0; i < 20; i++) drive(1'b1, 16'd100, 4);
    // ramp at R=4
    do_reset("reset_before_ramp");
    for (int i = 0; i < 20; i++) drive(1'b1, DW'(i), 4);
    // full-scale swing through the wrap at R=1
    do_reset("reset_before_wrap");
    drive(1'b1, 16'h7fff, 1);
    drive(1'b1, 16'h8000, 1);
    drive(1'b1, 16'h7fff, 0);
    drive(1'b1, 16'h8000, 0);
    for (int i = 0; i < 4; i++) drive(1'b0, 16'h1234, 1);
    // en toggling at R=3
    do_reset("reset_before_gated");
    for (int i = 0; i < 24; i++) drive(i[0] == 1'b0, DW'(i * 7), 3);
    // ratio lowered mid-count, then ratio 0
    do_reset("reset_before_ratio");
    for (int i = 0; i < 13; i++) drive(1'b1, DW'(i * 3), 8);
    for (int i = 0; i < 10; i++) drive(1'b1, DW'(200 + i), 2);
    for (int i = 0; i < 6; i++)  drive(1'b1, DW'(500 - i * 9), 0);
    // randomized run with changing ratio
    r = 5;
    for (int i = 0; i < 1500; i++) begin
      logic [DW-1:0] d;
      if (i % 60 == 0) begin
        case ($urandom_range(0, 5))
          0: r = 0;
          1: r = 1;
          2: r = 2;
          3: r = 3;
          4: r = 5;
          default: r = 7;
        endcase
      end
      case ($urandom_range(0, 5))
        0: d = 16'h7fff;
        1: d = 16'h8000;
        default: d = DW'($urandom);
      endcase
      drive($urandom_range(0, 3) != 0, d, r);
    end
    // reset with samples in flight, then one fresh sample
    for (int i = 0; i < 2; i++) drive(1'b1, 16'd999, 1);
    do_reset("reset_mid_flight");
    for (int i = 0; i < 6; i++) drive(1'b0, 16'd77, 1);
    drive(1'b1, 16'd50, 1);
    drive(1'b0, 16'd0, 1);

    for (int i = 0; i < 20 && exp_d.size() > 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (exp_d.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d required 0", exp_d.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
